// File: rtl/tiny_dnn_pkg.sv
// -----------------------------------------------------------------------------
// tiny_dnn_pkg
// Shared widths and types for the tiny_dnn sequencer, register block and
// buffers, so all of them agree on address and counter sizes.
//   ADDR_W : input/weight/output buffer address width
//   CNT_W  : kernel/spatial counter width (kh, kw, oh, ow, iw)
//   CH_W   : channel counter limit width (id)
//   IS_W   : channel plane stride width (is)
//   state_e: sequencer FSM states
// -----------------------------------------------------------------------------
package tiny_dnn_pkg;

    localparam int ADDR_W = 12;
    localparam int CNT_W  = 5;
    localparam int CH_W   = 4;
    localparam int IS_W   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tiny_dnn_cnt.sv
// -----------------------------------------------------------------------------
// tiny_dnn_cnt
// Wrap counter used for each loop level of the sequencer. Counts 0..limit_i
// while en_i is high and returns to 0 after reaching limit_i.
// Ports:
//   clk, srst     : clock and synchronous active-high reset
//   clr_i         : force the count to 0 on the next edge (overrides en_i)
//   en_i          : advance by one step this cycle
//   limit_i       : terminal value (inclusive)
//   cnt_next_o    : value the counter will hold after this edge
//   term_o        : current value equals limit_i
//   wrap_o        : stepping past limit_i this cycle (carry into next level)
// -----------------------------------------------------------------------------
module tiny_dnn_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_next_o,
    output logic         term_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Equality (not >=) is deliberate: if the limit changes mid-pass the
    // counter simply rolls over modulo 2^W and the loop still terminates.
    assign term_o = (cnt_q == limit_i);
    assign wrap_o = en_i & term_o;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = term_o ? '0 : cnt_q + W'(1);
        end
    end

    assign cnt_next_o = cnt_d;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tiny_dnn_seq.sv
// -----------------------------------------------------------------------------
// tiny_dnn_seq
// Loop sequencer for the tiny_dnn convolution/FC datapath. Walks
// kx (innermost), ky, c, ox, oy (outermost) and presents one MAC term per
// cycle using incremental pointer arithmetic only.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET : clock, synchronous active-high reset
//   run                      : rising edge starts a pass, low aborts
//   id, is, iw, oh, ow, kh, kw : static shape configuration (limits are N-1)
//   stall                    : datapath not ready, hold everything
//   src_a, wgt_a, dst_a      : input / weight / output buffer addresses
//   vld                      : src_a/wgt_a valid
//   acc_clr, acc_wr          : first / last MAC term of an output pixel
//   busy                     : pass in progress (RUN or DONE)
//   done                     : one-cycle pulse after the final term
// -----------------------------------------------------------------------------
module tiny_dnn_seq
    import tiny_dnn_pkg::*;
#(
    parameter int AW   = ADDR_W,
    parameter int DW_K = CNT_W
) (
    input  logic            S_AXI_ACLK,
    input  logic            S_AXI_ARESET,
    input  logic            run,
    input  logic [CH_W-1:0] id,
    input  logic [IS_W-1:0] is,
    input  logic [DW_K-1:0] iw,
    input  logic [DW_K-1:0] oh,
    input  logic [DW_K-1:0] ow,
    input  logic [DW_K-1:0] kh,
    input  logic [DW_K-1:0] kw,
    input  logic            stall,
    output logic [AW-1:0]   src_a,
    output logic [AW-1:0]   wgt_a,
    output logic [AW-1:0]   dst_a,
    output logic            vld,
    output logic            acc_clr,
    output logic            acc_wr,
    output logic            busy,
    output logic            done
);

    localparam int NLVL = 5;  // 0:kx 1:ky 2:c 3:ox 4:oy

    state_e state_q;
    logic   run_q;

    logic [AW-1:0] src_a_q, wgt_a_q, dst_a_q;
    logic          vld_q, acc_clr_q, acc_wr_q, busy_q, done_q;

    // ---------------------------------------------------------------------
    // Loop counters, chained by wrap
    // ---------------------------------------------------------------------
    logic            adv;
    logic            cnt_clr;
    logic            cnt_en   [NLVL];
    logic            cnt_term [NLVL];
    logic            cnt_wrap [NLVL];
    logic [DW_K-1:0] cnt_lim  [NLVL];
    logic [DW_K-1:0] cnt_nxt  [NLVL];

    // A term is consumed only in RUN with run still high and no stall.
    assign adv     = (state_q == RUN) && run && !stall;
    // Counters sit at zero outside RUN, so the first term after start falls
    // out of the same next-value path as every later term.
    assign cnt_clr = (state_q != RUN);

    assign cnt_lim[0] = kw;
    assign cnt_lim[1] = kh;
    assign cnt_lim[2] = DW_K'(id);
    assign cnt_lim[3] = ow;
    assign cnt_lim[4] = oh;

    always_comb begin
        for (int i = 0; i < NLVL; i++) begin
            cnt_en[i] = 1'b0;
        end
        cnt_en[0] = adv;
        for (int i = 1; i < NLVL; i++) begin
            cnt_en[i] = cnt_en[i-1] & cnt_term[i-1];
        end
    end

    generate
        for (genvar gi = 0; gi < NLVL; gi++) begin : g_cnt
            tiny_dnn_cnt #(
                .W (DW_K)
            ) u_cnt (
                .clk        (S_AXI_ACLK),
                .srst       (S_AXI_ARESET),
                .clr_i      (cnt_clr),
                .en_i       (cnt_en[gi]),
                .limit_i    (cnt_lim[gi]),
                .cnt_next_o (cnt_nxt[gi]),
                .term_o     (cnt_term[gi]),
                .wrap_o     (cnt_wrap[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Pointers (all modulo 2^AW)
    //   pix   : oy*iw + ox        row_q : oy*iw
    //   cbase : c*is              krow  : c*is + ky*iw
    // ---------------------------------------------------------------------
    logic [AW-1:0] pix_q,   pix_d;
    logic [AW-1:0] row_q,   row_d;
    logic [AW-1:0] cbase_q, cbase_d;
    logic [AW-1:0] krow_q,  krow_d;
    logic [AW-1:0] wgt_q,   wgt_d;
    logic [AW-1:0] dst_q,   dst_d;
    logic [AW-1:0] iw_ext, is_ext;
    logic          last;

    assign iw_ext = AW'(iw);
    assign is_ext = AW'(is);
    assign last   = cnt_wrap[NLVL-1];

    // Higher loop levels override lower ones: a wrap at level n implies a
    // wrap at every level below it.
    always_comb begin
        pix_d   = pix_q;
        row_d   = row_q;
        cbase_d = cbase_q;
        krow_d  = krow_q;
        wgt_d   = wgt_q;
        dst_d   = dst_q;
        if (state_q != RUN) begin
            pix_d   = '0;
            row_d   = '0;
            cbase_d = '0;
            krow_d  = '0;
            wgt_d   = '0;
            dst_d   = '0;
        end else if (adv) begin
            wgt_d = wgt_q + AW'(1);
            if (cnt_wrap[0]) begin
                krow_d = krow_q + iw_ext;
            end
            if (cnt_wrap[1]) begin
                cbase_d = cbase_q + is_ext;
                krow_d  = cbase_q + is_ext;
            end
            if (cnt_wrap[2]) begin
                // new output pixel
                cbase_d = '0;
                krow_d  = '0;
                wgt_d   = '0;
                dst_d   = dst_q + AW'(1);
                pix_d   = pix_q + AW'(1);
            end
            if (cnt_wrap[3]) begin
                row_d = row_q + iw_ext;
                pix_d = row_q + iw_ext;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            pix_q   <= '0;
            row_q   <= '0;
            cbase_q <= '0;
            krow_q  <= '0;
            wgt_q   <= '0;
            dst_q   <= '0;
        end else begin
            pix_q   <= pix_d;
            row_q   <= row_d;
            cbase_q <= cbase_d;
            krow_q  <= krow_d;
            wgt_q   <= wgt_d;
            dst_q   <= dst_d;
        end
    end

    // Attributes of the term that the next edge will present.
    logic [AW-1:0] src_next;
    logic          clr_next;
    logic          wr_next;

    assign src_next = pix_d + krow_d + AW'(cnt_nxt[0]);
    assign clr_next = (cnt_nxt[0] == '0) && (cnt_nxt[1] == '0) && (cnt_nxt[2] == '0);
    assign wr_next  = (cnt_nxt[0] == kw) && (cnt_nxt[1] == kh) && (cnt_nxt[2] == DW_K'(id));

    // ---------------------------------------------------------------------
    // FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q   <= IDLE;
            run_q     <= 1'b0;
            src_a_q   <= '0;
            wgt_a_q   <= '0;
            dst_a_q   <= '0;
            vld_q     <= 1'b0;
            acc_clr_q <= 1'b0;
            acc_wr_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            run_q <= run;
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (run && !run_q) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        vld_q     <= 1'b1;
                        src_a_q   <= src_next;
                        wgt_a_q   <= wgt_d;
                        dst_a_q   <= dst_d;
                        acc_clr_q <= clr_next;
                        acc_wr_q  <= wr_next;
                    end
                end
                RUN: begin
                    if (!run) begin
                        // abort: no done pulse
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        vld_q     <= 1'b0;
                        acc_clr_q <= 1'b0;
                        acc_wr_q  <= 1'b0;
                    end else if (!stall) begin
                        if (last) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            vld_q     <= 1'b0;
                            acc_clr_q <= 1'b0;
                            acc_wr_q  <= 1'b0;
                        end else begin
                            vld_q     <= 1'b1;
                            src_a_q   <= src_next;
                            wgt_a_q   <= wgt_d;
                            dst_a_q   <= dst_d;
                            acc_clr_q <= clr_next;
                            acc_wr_q  <= wr_next;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    vld_q     <= 1'b0;
                    acc_clr_q <= 1'b0;
                    acc_wr_q  <= 1'b0;
                end
            endcase
        end
    end

    assign src_a   = src_a_q;
    assign wgt_a   = wgt_a_q;
    assign dst_a   = dst_a_q;
    assign vld     = vld_q;
    assign acc_clr = acc_clr_q;
    assign acc_wr  = acc_wr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_tiny_dnn_seq.sv
`timescale 1ns/1ps
module tb_tiny_dnn_seq;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          srst, run, stall;
    logic [3:0]    id;
    logic [9:0]    is_c;
    logic [4:0]    iw, oh, ow, kh, kw;
    logic [AW-1:0] src_a, wgt_a, dst_a;
    logic          vld, acc_clr, acc_wr, busy, done;

    always #5 clk = ~clk;

    tiny_dnn_seq #(
        .AW   (12),
        .DW_K (5)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (srst),
        .run          (run),
        .id           (id),
        .is           (is_c),
        .iw           (iw),
        .oh           (oh),
        .ow           (ow),
        .kh           (kh),
        .kw           (kw),
        .stall        (stall),
        .src_a        (src_a),
        .wgt_a        (wgt_a),
        .dst_a        (dst_a),
        .vld          (vld),
        .acc_clr      (acc_clr),
        .acc_wr       (acc_wr),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        int            cs;
        logic [AW-1:0] src;
        logic [AW-1:0] wgt;
        logic [AW-1:0] dst;
        logic          clr;
        logic          wr;
    } vec_t;

    typedef struct {
        logic [3:0] id;
        logic [9:0] is;
        logic [4:0] iw;
        logic [4:0] oh;
        logic [4:0] ow;
        logic [4:0] kh;
        logic [4:0] kw;
    } cfg_t;

    vec_t vecs[$];
    cfg_t cfgs[4];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(int cs, int src, int wgt, int dst, bit clr, bit wr);
        vec_t v;
        v.cs  = cs;
        v.src = AW'(src);
        v.wgt = AW'(wgt);
        v.dst = AW'(dst);
        v.clr = clr;
        v.wr  = wr;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic chk_term(input int cs, input int k, input vec_t v);
        $display("case%0d term %0d: vld=%0b src=%0d wgt=%0d dst=%0d clr=%0b wr=%0b",
                 cs, k, vld, src_a, wgt_a, dst_a, acc_clr, acc_wr);
        chk($sformatf("c%0d_t%0d_vld", cs, k), 32'(vld), 32'd1);
        chk($sformatf("c%0d_t%0d_src", cs, k), 32'(src_a), 32'(v.src));
        chk($sformatf("c%0d_t%0d_wgt", cs, k), 32'(wgt_a), 32'(v.wgt));
        chk($sformatf("c%0d_t%0d_dst", cs, k), 32'(dst_a), 32'(v.dst));
        chk($sformatf("c%0d_t%0d_clr", cs, k), 32'(acc_clr), 32'(v.clr));
        chk($sformatf("c%0d_t%0d_wr", cs, k), 32'(acc_wr), 32'(v.wr));
    endtask

    task automatic set_cfg(input int cs);
        id   = cfgs[cs].id;
        is_c = cfgs[cs].is;
        iw   = cfgs[cs].iw;
        oh   = cfgs[cs].oh;
        ow   = cfgs[cs].ow;
        kh   = cfgs[cs].kh;
        kw   = cfgs[cs].kw;
    endtask

    // One full pass; optional stall of 2 cycles on terms 3 and 6 (1-based).
    task automatic run_pass(input int cs, input bit stall_mode);
        int k;
        int vcnt;
        set_cfg(cs);
        stall = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        run = 1'b1;
        k    = 0;
        vcnt = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].cs == cs) begin
                @(negedge clk);
                chk_term(cs, k, vecs[i]);
                chk($sformatf("c%0d_t%0d_busy", cs, k), 32'(busy), 32'd1);
                if (vld === 1'b1) vcnt++;
                if (stall_mode && (k == 2 || k == 5)) begin
                    stall = 1'b1;
                    for (int s = 0; s < 2; s++) begin
                        @(negedge clk);
                        chk_term(cs, k, vecs[i]);
                        if (vld === 1'b1) vcnt++;
                    end
                    stall = 1'b0;
                end
                k++;
            end
        end
        @(negedge clk);
        $display("case%0d end: done=%0b busy=%0b vld=%0b", cs, done, busy, vld);
        chk($sformatf("c%0d_done_pulse", cs), 32'(done), 32'd1);
        chk($sformatf("c%0d_busy_in_done", cs), 32'(busy), 32'd1);
        chk($sformatf("c%0d_vld_in_done", cs), 32'(vld), 32'd0);
        @(negedge clk);
        chk($sformatf("c%0d_done_low", cs), 32'(done), 32'd0);
        chk($sformatf("c%0d_busy_low", cs), 32'(busy), 32'd0);
        chk($sformatf("c%0d_vld_count", cs), 32'(vcnt), 32'(k + (stall_mode ? 4 : 0)));
    endtask

    initial begin
        int s2[8];
        int org[4];

        srst = 1'b1; run = 1'b0; stall = 1'b0;
        id = '0; is_c = '0; iw = '0; oh = '0; ow = '0; kh = '0; kw = '0;

        // configurations: id, is, iw, oh, ow, kh, kw
        cfgs[0] = '{id: 4'd0, is: 10'd0,  iw: 5'd4, oh: 5'd0, ow: 5'd3, kh: 5'd0, kw: 5'd0};
        cfgs[1] = '{id: 4'd1, is: 10'd16, iw: 5'd4, oh: 5'd0, ow: 5'd0, kh: 5'd1, kw: 5'd1};
        cfgs[2] = '{id: 4'd0, is: 10'd0,  iw: 5'd0, oh: 5'd0, ow: 5'd0, kh: 5'd0, kw: 5'd0};
        cfgs[3] = '{id: 4'd0, is: 10'd0,  iw: 5'd3, oh: 5'd1, ow: 5'd1, kh: 5'd1, kw: 5'd1};

        // case 0: four 1x1 pixels
        for (int i = 0; i < 4; i++) add(0, i, 0, i, 1'b1, 1'b1);
        // case 1: 2x2x2 kernel on one pixel
        s2 = '{0, 1, 4, 5, 16, 17, 20, 21};
        for (int i = 0; i < 8; i++) add(1, s2[i], i, 0, i == 0, i == 7);
        // case 2: all-zero configuration
        add(2, 0, 0, 0, 1'b1, 1'b1);
        // case 3: 2x2 output, 2x2 kernel, iw=3; pixel origins 0,1,3,4
        org = '{0, 1, 3, 4};
        for (int p = 0; p < 4; p++)
            for (int t = 0; t < 4; t++)
                add(3, org[p] + (t / 2) * 3 + (t % 2), t, p, t == 0, t == 3);

        repeat (3) @(negedge clk);
        $display("reset: vld=%0b busy=%0b done=%0b src=%0d wgt=%0d dst=%0d", vld, busy, done, src_a, wgt_a, dst_a);
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_src", 32'(src_a), 32'd0);
        chk("rst_wgt", 32'(wgt_a), 32'd0);
        chk("rst_dst", 32'(dst_a), 32'd0);
        chk("rst_clr", 32'(acc_clr), 32'd0);
        chk("rst_wr", 32'(acc_wr), 32'd0);
        srst = 1'b0;

        run_pass(0, 1'b0);
        run_pass(1, 1'b0);
        run_pass(1, 1'b1);

        // abort after the second term, then restart
        set_cfg(0);
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        chk("abort_t0_src", 32'(src_a), 32'd0);
        @(negedge clk);
        chk("abort_t1_src", 32'(src_a), 32'd1);
        run = 1'b0;
        @(negedge clk);
        $display("abort: vld=%0b busy=%0b done=%0b", vld, busy, done);
        chk("abort_vld", 32'(vld), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wr", 32'(acc_wr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        run_pass(0, 1'b0);

        // single term, then run held high must not restart
        run_pass(2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_vld", 32'(vld), 32'd0);
            chk("hold_busy", 32'(busy), 32'd0);
            chk("hold_done", 32'(done), 32'd0);
        end
        run = 1'b0;

        run_pass(3, 1'b0);

        // reset mid-pass
        set_cfg(1);
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mrst_pre_src", 32'(src_a), 32'd1);
        srst = 1'b1;
        run  = 1'b0;
        @(negedge clk);
        $display("mid-pass reset: vld=%0b busy=%0b done=%0b src=%0d wgt=%0d", vld, busy, done, src_a, wgt_a);
        chk("mrst_vld", 32'(vld), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_src", 32'(src_a), 32'd0);
        chk("mrst_wgt", 32'(wgt_a), 32'd0);
        srst = 1'b0;
        @(negedge clk);
        chk("mrst_after_done", 32'(done), 32'd0);
        chk("mrst_after_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
